// File: rtl/ext_unit_pipe.sv
// Extract-and-extend unit: picks a byte/half/word field by byte offset, extends or places it,
// and buffers the result in a 2-entry FIFO with valid/ready handshakes on both sides.
module ext_unit_pipe #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] in_offset,
    input  logic [1:0]                      in_size,
    input  logic [1:0]                      in_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_err
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] word_t;

    int unsigned fw_bytes;
    int unsigned fw_bits;
    int unsigned off_bytes;
    word_t       shifted;
    word_t       mask;
    word_t       field;
    word_t       res_data;
    logic        sign_bit;
    logic        res_err;

    always_comb begin
        fw_bytes  = 32'd1 << in_size;
        fw_bits   = fw_bytes << 3;
        off_bytes = 32'(in_offset);
        shifted   = in_data >> (off_bytes << 3);
        mask      = (fw_bits >= DATA_WIDTH) ? '1 : ((word_t'(1) << fw_bits) - word_t'(1));
        field     = shifted & mask;
        sign_bit  = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i == fw_bits - 32'd1) sign_bit = shifted[i];
        end
        res_err = (fw_bits > DATA_WIDTH) ||
                  ((off_bytes & (fw_bytes - 32'd1)) != 32'd0) ||
                  (off_bytes + fw_bytes > NBYTES);
        res_data = '0;
        if (in_mode == 2'd3) begin
            res_err  = 1'b0;
            res_data = in_data;
        end else if (!res_err) begin
            case (in_mode)
                2'd0:    res_data = sign_bit ? (field | ~mask) : field;
                2'd1:    res_data = field;
                default: res_data = field << (DATA_WIDTH - fw_bits);
            endcase
        end
    end

    // FIFO storage; in_ready depends only on the registered count
    logic [1:0][DATA_WIDTH-1:0] mem_data_q;
    logic [1:0]                 mem_err_q;
    logic                       wr_ptr_q;
    logic                       rd_ptr_q;
    logic [1:0]                 count_q;
    logic [1:0]                 count_d;
    logic                       push;
    logic                       pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_err   = mem_err_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_data_q <= '0;
            mem_err_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= res_data;
                mem_err_q[wr_ptr_q]  <= res_err;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed and random-stream bench for ext_unit_pipe (32-bit instance plus a 64-bit instance).
module tb_ext_unit_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_offset, in_size, in_mode;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_err;
    logic [63:0] w_in_data, w_out_data;
    logic [2:0]  w_in_offset;
    logic [1:0]  w_in_size, w_in_mode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ext_unit_pipe #(.DATA_WIDTH(32)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_offset(in_offset), .in_size(in_size), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    ext_unit_pipe #(.DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_offset(w_in_offset), .in_size(w_in_size), .in_mode(w_in_mode),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .out_err(w_out_err)
    );

    // Reference for the 32-bit instance: returns {err, data}
    function automatic logic [32:0] ref_ext(input logic [31:0] d, input int off, input int size,
                                            input int mode);
        logic [31:0] f;
        int          nb;
        nb = 1 << size;
        if (mode == 3) return {1'b0, d};
        if (nb > 4 || (off % nb) != 0 || off + nb > 4) return {1'b1, 32'h0};
        f = d >> (off * 8);
        case (size)
            0: case (mode)
                   0:       return {1'b0, {24{f[7]}}, f[7:0]};
                   1:       return {1'b0, 24'h0, f[7:0]};
                   default: return {1'b0, f[7:0], 24'h0};
               endcase
            1: case (mode)
                   0:       return {1'b0, {16{f[15]}}, f[15:0]};
                   1:       return {1'b0, 16'h0, f[15:0]};
                   default: return {1'b0, f[15:0], 16'h0};
               endcase
            default: return {1'b0, f};
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset out_data/err: got %h/%b want 0/0", out_data, out_err);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    // Each row: data, offset, size, mode, expected data, expected err
    task automatic test_extract();
        logic [31:0] t_d [13] = '{32'h1234_80FF, 32'h1234_80FF, 32'h1234_80FF, 32'h1234_80FF,
                                  32'h1234_80FF, 32'h1234_80FF, 32'h1234_80FF, 32'h1234_80FF,
                                  32'h8765_4321, 32'h1234_80FF, 32'h1234_80FF, 32'h1234_80FF,
                                  32'hDEAD_BEEF};
        int          t_o [13] = '{0, 0, 1, 2, 0, 3, 3, 0, 0, 1, 2, 0, 3};
        int          t_s [13] = '{0, 0, 0, 1, 1, 0, 0, 2, 2, 1, 2, 3, 3};
        int          t_m [13] = '{0, 1, 0, 0, 0, 2, 3, 0, 2, 0, 1, 0, 3};
        logic [31:0] t_e [13] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FF80, 32'h0000_1234,
                                  32'hFFFF_80FF, 32'h1200_0000, 32'h1234_80FF, 32'h1234_80FF,
                                  32'h8765_4321, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
        logic        t_r [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid  = 1'b1;
            in_data   = t_d[i];
            in_offset = 2'(t_o[i]);
            in_size   = 2'(t_s[i]);
            in_mode   = 2'(t_m[i]);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== t_e[i] || out_err !== t_r[i]) begin
                n_fail++;
                $display("FAIL extract[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         i, out_valid, out_data, out_err, t_e[i], t_r[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        logic [63:0] t_e [3] = '{64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FEDC_BA98, 64'h0};
        logic [2:0]  t_o [3] = '{3'd0, 3'd4, 3'd4};
        logic [1:0]  t_s [3] = '{2'd3, 2'd2, 2'd3};
        logic        t_r [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            w_in_valid  = 1'b1;
            w_in_data   = 64'hFEDC_BA98_7654_3210;
            w_in_offset = t_o[i];
            w_in_size   = t_s[i];
            w_in_mode   = 2'd0;
            @(posedge clk);
            @(negedge clk);
            w_in_valid = 1'b0;
            n_checks++;
            if (w_out_valid !== 1'b1 || w_out_data !== t_e[i] || w_out_err !== t_r[i]) begin
                n_fail++;
                $display("FAIL wide[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         i, w_out_valid, w_out_data, w_out_err, t_e[i], t_r[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_mode   = 2'd3;
        in_offset = 2'd0;
        in_size   = 2'd0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_0001;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hAAAA_0001) begin
            n_fail++;
            $display("FAIL bp_first: got rdy=%b v=%b d=%h want 1/1/aaaa0001",
                     in_ready, out_valid, out_data);
        end
        in_data = 32'hBBBB_0002;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full in_ready: got %b want 0", in_ready);
        end
        in_data = 32'hCCCC_0003;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hAAAA_0001) begin
            n_fail++;
            $display("FAIL bp_stall: got rdy=%b d=%h want 0/aaaa0001", in_ready, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hBBBB_0002) begin
            n_fail++;
            $display("FAIL bp_second: got rdy=%b v=%b d=%h want 1/1/bbbb0002",
                     in_ready, out_valid, out_data);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0003) begin
            n_fail++;
            $display("FAIL bp_third: got v=%b d=%h want 1/cccc0003", out_valid, out_data);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        logic [32:0] exp_q[$];
        logic [32:0] exp;
        int          off, size, mode;
        logic [31:0] d;
        out_ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || {out_err, out_data} !== exp) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: got v=%b rdy=%b e=%b d=%h want v=1 rdy=1 e=%b d=%h",
                             i - 1, out_valid, in_ready, out_err, out_data, exp[32], exp[31:0]);
                end
            end
            if (i < 100) begin
                d    = $urandom;
                off  = $urandom_range(0, 3);
                size = $urandom_range(0, 3);
                mode = $urandom_range(0, 3);
                in_valid  = 1'b1;
                in_data   = d;
                in_offset = 2'(off);
                in_size   = 2'(size);
                in_mode   = 2'(mode);
                exp_q.push_back(ref_ext(d, off, size, mode));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_size   = 2'd0;
        in_offset = 2'd0;
        in_data   = 32'h0000_0055;
        @(posedge clk); @(negedge clk);
        in_data = 32'h0000_0066;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid full: got in_ready=%b want 0", in_ready);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid async: got v=%b d=%h e=%b want 0/0/0", out_valid, out_data, out_err);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        in_valid  = 1'b1;
        in_data   = 32'h0000_00F7;
        in_mode   = 2'd0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFF7 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid next: got v=%b d=%h e=%b want 1/fffffff7/0",
                     out_valid, out_data, out_err);
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in_data     = '0;
        in_offset   = '0;
        in_size     = '0;
        in_mode     = '0;
        w_in_valid  = 1'b0;
        w_in_data   = '0;
        w_in_offset = '0;
        w_in_size   = '0;
        w_in_mode   = '0;
        @(negedge clk);
        test_reset();
        test_extract();
        test_wide();
        test_backpressure();
        test_stream();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
